// File: rtl/gte_mac_accum_if.sv
// Handshake/result bundle between the GTE multiply path, the MAC accumulator
// and the MACn/IRn/FLAG write-back logic.
interface gte_mac_accum_if #(
  parameter int PROD_W = 35
);
  logic                     i_valid;
  logic                     i_first;
  logic                     i_last;
  logic signed [PROD_W-1:0] i_product;
  logic                     i_useBias;
  logic signed [31:0]       i_bias;
  logic                     i_sf;
  logic                     i_lm;
  logic                     o_valid;
  logic [31:0]              o_mac;
  logic [15:0]              o_ir;
  logic                     o_ovfPos;
  logic                     o_ovfNeg;
  logic                     o_irSat;
  logic                     o_busy;

  modport slave (
    input  i_valid, i_first, i_last, i_product, i_useBias, i_bias, i_sf, i_lm,
    output o_valid, o_mac, o_ir, o_ovfPos, o_ovfNeg, o_irSat, o_busy
  );

  modport master (
    output i_valid, i_first, i_last, i_product, i_useBias, i_bias, i_sf, i_lm,
    input  o_valid, o_mac, o_ir, o_ovfPos, o_ovfNeg, o_irSat, o_busy
  );
endinterface

// File: rtl/gte_mac_accum.sv
// GTE MAC accumulator: sums up to three signed products plus an optional
// pre-shifted bias, then produces MAC/IR results with overflow/saturation flags.
//
// state | meaning
// IDLE  | waiting for a first term
// ACCUM | partial sum held, o_busy=1
// DONE  | one-cycle o_valid pulse; a new first term may start here
module gte_mac_accum #(
  parameter int PROD_W = 35,
  parameter int ACC_W  = 44,
  parameter int SHIFT  = 12
) (
  input  logic            i_clk,
  input  logic            i_rst,
  gte_mac_accum_if.slave  bus
);
  localparam int SUM_W = ACC_W + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_pos_q, ovf_pos_d;
  logic               ovf_neg_q, ovf_neg_d;
  logic [31:0]        mac_q, mac_d;
  logic [15:0]        ir_q, ir_d;
  logic               res_pos_q, res_pos_d;
  logic               res_neg_q, res_neg_d;
  logic               sat_q, sat_d;

  logic               take;
  logic               start;
  logic [SUM_W-1:0]   base;
  logic [SUM_W-1:0]   sum;
  logic               pos_now;
  logic               neg_now;
  logic               pos_new;
  logic               neg_new;
  logic [ACC_W-1:0]   acc_new;
  logic signed [31:0] mac_new;
  logic signed [31:0] ir_lo;
  logic [15:0]        ir_new;
  logic               sat_new;

  always_comb begin
    take    = 1'b0;
    start   = bus.i_valid & bus.i_first;
    base    = '0;
    sum     = '0;
    pos_now = 1'b0;
    neg_now = 1'b0;
    pos_new = 1'b0;
    neg_new = 1'b0;
    acc_new = '0;
    mac_new = '0;
    ir_lo   = '0;
    ir_new  = '0;
    sat_new = 1'b0;

    state_d   = state_q;
    acc_d     = acc_q;
    ovf_pos_d = ovf_pos_q;
    ovf_neg_d = ovf_neg_q;
    mac_d     = mac_q;
    ir_d      = ir_q;
    res_pos_d = res_pos_q;
    res_neg_d = res_neg_q;
    sat_d     = sat_q;

    case (state_q)
      ACCUM:   take = bus.i_valid;
      default: take = start;
    endcase

    if (start) begin
      if (bus.i_useBias)
        base = {{(SUM_W-32-SHIFT){bus.i_bias[31]}}, bus.i_bias, {SHIFT{1'b0}}};
    end else begin
      base = {{2{acc_q[ACC_W-1]}}, acc_q};
    end
    sum = base + {{(SUM_W-PROD_W){bus.i_product[PROD_W-1]}}, bus.i_product};

    // Top three bits disagreeing means the sum left the signed ACC_W range.
    pos_now = ~sum[SUM_W-1] & (sum[SUM_W-1:ACC_W-1] != 3'b000);
    neg_now =  sum[SUM_W-1] & (sum[SUM_W-1:ACC_W-1] != 3'b111);
    pos_new = (ovf_pos_q & ~start) | pos_now;
    neg_new = (ovf_neg_q & ~start) | neg_now;
    acc_new = sum[ACC_W-1:0];

    // Only bits [31:0] of the shifted value survive, so a plain slice suffices.
    mac_new = bus.i_sf ? acc_new[SHIFT+31:SHIFT] : acc_new[31:0];
    ir_lo   = bus.i_lm ? 32'sd0 : -32'sd32768;
    if (mac_new > 32'sd32767) begin
      ir_new  = 16'h7FFF;
      sat_new = 1'b1;
    end else if (mac_new < ir_lo) begin
      ir_new  = ir_lo[15:0];
      sat_new = 1'b1;
    end else begin
      ir_new  = mac_new[15:0];
    end

    if (take) begin
      acc_d     = acc_new;
      ovf_pos_d = pos_new;
      ovf_neg_d = neg_new;
      if (bus.i_last) begin
        state_d   = DONE;
        mac_d     = mac_new;
        ir_d      = ir_new;
        res_pos_d = pos_new;
        res_neg_d = neg_new;
        sat_d     = sat_new;
      end else begin
        state_d   = ACCUM;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      ovf_pos_q <= 1'b0;
      ovf_neg_q <= 1'b0;
      mac_q     <= '0;
      ir_q      <= '0;
      res_pos_q <= 1'b0;
      res_neg_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_pos_q <= ovf_pos_d;
      ovf_neg_q <= ovf_neg_d;
      mac_q     <= mac_d;
      ir_q      <= ir_d;
      res_pos_q <= res_pos_d;
      res_neg_q <= res_neg_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_busy   = (state_q == ACCUM);
  assign bus.o_mac    = mac_q;
  assign bus.o_ir     = ir_q;
  assign bus.o_ovfPos = res_pos_q;
  assign bus.o_ovfNeg = res_neg_q;
  assign bus.o_irSat  = sat_q;
endmodule

// File: tb/tb_gte_mac_accum.sv
// Scoreboard bench for gte_mac_accum: directed cases plus randomized term
// sequences checked against an integer-arithmetic reference model.
module tb_gte_mac_accum;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  gte_mac_accum_if #(.PROD_W(35)) bus ();

  gte_mac_accum #(.PROD_W(35), .ACC_W(44), .SHIFT(12)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  typedef struct {
    longint due;
    longint mac;
    longint ir;
    bit     pos;
    bit     neg;
    bit     sat;
  } exp_t;

  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  // reference model state
  bit     m_active = 0;
  longint m_acc    = 0;
  bit     m_pos    = 0;
  bit     m_neg    = 0;

  localparam longint ACC_MAX = (64'sd1 <<< 43) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< 43);

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint wrap44(input longint x);
    longint y;
    y = x & ((64'sd1 <<< 44) - 1);
    if (y > ACC_MAX) y = y - (64'sd1 <<< 44);
    return y;
  endfunction

  task automatic idle_inputs();
    bus.i_valid   = 0;
    bus.i_first   = 0;
    bus.i_last    = 0;
    bus.i_product = '0;
    bus.i_useBias = 0;
    bus.i_bias    = '0;
    bus.i_sf      = 0;
    bus.i_lm      = 0;
  endtask

  task automatic idle_cycle();
    @(negedge i_clk);
    idle_inputs();
  endtask

  // Drive one product term on the next negedge and advance the model.
  task automatic term(input bit first, input bit last, input longint p,
                      input bit ub, input longint bias, input bit sf, input bit lm);
    longint sum, s, mac;
    exp_t   e;
    @(negedge i_clk);
    bus.i_valid   = 1;
    bus.i_first   = first;
    bus.i_last    = last;
    bus.i_product = p[34:0];
    bus.i_useBias = ub;
    bus.i_bias    = bias[31:0];
    bus.i_sf      = sf;
    bus.i_lm      = lm;
    if (!first && !m_active) return;
    if (first) begin
      sum   = p + (ub ? bias * 4096 : 0);
      m_pos = 0;
      m_neg = 0;
    end else begin
      sum = m_acc + p;
    end
    if (sum > ACC_MAX) m_pos = 1;
    if (sum < ACC_MIN) m_neg = 1;
    m_acc = wrap44(sum);
    if (last) begin
      s   = sf ? (m_acc >>> 12) : m_acc;
      mac = longint'(int'(s));
      e.due = cyc + 1;
      e.mac = mac;
      e.pos = m_pos;
      e.neg = m_neg;
      if (mac > 32767) begin
        e.ir = 32767; e.sat = 1;
      end else if (mac < (lm ? 0 : -32768)) begin
        e.ir = lm ? 0 : -32768; e.sat = 1;
      end else begin
        e.ir = mac; e.sat = 0;
      end
      sb.push_back(e);
      m_active = 0;
    end else begin
      m_active = 1;
    end
  endtask

  // monitor
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && bus.o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_o_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency",  cyc, e.due);
        chk("o_mac",    longint'($signed(bus.o_mac)), e.mac);
        chk("o_ir",     longint'($signed(bus.o_ir)), e.ir);
        chk("o_ovfPos", longint'(bus.o_ovfPos), longint'(e.pos));
        chk("o_ovfNeg", longint'(bus.o_ovfNeg), longint'(e.neg));
        chk("o_irSat",  longint'(bus.o_irSat), longint'(e.sat));
      end
    end
  end

  function automatic longint rnd_prod(input int mode);
    longint p;
    case (mode)
      0: p = longint'($urandom_range(0, 2000000)) - 1000000;
      1: p = longint'($urandom_range(0, 400)) * 4096 - 200 * 4096;
      default: begin
        p = {32'd0, $urandom} | (longint'($urandom_range(0, 7)) <<< 32);
        if (p >= (64'sd1 <<< 34)) p = p - (64'sd1 <<< 35);
      end
    endcase
    return p;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},  longint'(bus.o_busy), 0);
    chk({tag, "_valid"}, longint'(bus.o_valid), 0);
    chk({tag, "_mac"},   longint'(bus.o_mac), 0);
    chk({tag, "_ir"},    longint'(bus.o_ir), 0);
    chk({tag, "_flags"}, longint'({bus.o_ovfPos, bus.o_ovfNeg, bus.o_irSat}), 0);
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(negedge i_clk);
    i_rst = 0;
    check_outputs_zero("reset");

    // basic three-term accumulation
    term(1, 0, 409600, 0, 0, 1, 0);
    term(0, 0, 409600, 0, 0, 1, 0);
    term(0, 1, 409600, 0, 0, 1, 0);
    idle_cycle();
    // bias with positive overflow
    term(1, 1, 8192, 1, 64'sh7FFFFFFF, 0, 0);
    idle_cycle();
    // lm clamp both ways
    term(1, 1, -20480, 0, 0, 1, 1);
    idle_cycle();
    term(1, 1, -20480, 0, 0, 1, 0);
    idle_cycle();
    // upper saturation
    term(1, 1, 65536 * 4096, 0, 0, 1, 0);
    idle_cycle();
    idle_cycle();

    // stray valid in IDLE
    term(0, 0, 12345, 0, 0, 0, 0);
    idle_cycle();
    chk("stray_busy", longint'(bus.o_busy), 0);
    // restart drops old partial sum
    term(1, 0, 100, 0, 0, 0, 0);
    idle_cycle();
    chk("accum_busy", longint'(bus.o_busy), 1);
    term(1, 1, 7, 0, 0, 0, 0);
    idle_cycle();
    idle_cycle();

    // reset mid-operation
    term(1, 0, 409600, 0, 0, 1, 0);
    term(0, 0, 409600, 0, 0, 1, 0);
    @(negedge i_clk);
    idle_inputs();
    i_rst = 1;
    m_active = 0;
    @(negedge i_clk);
    i_rst = 0;
    check_outputs_zero("midrst");
    term(1, 0, 4096 * 5, 1, 3, 1, 0);
    term(0, 0, 4096 * 6, 0, 0, 1, 0);
    term(0, 1, -4096 * 2, 0, 0, 1, 0);
    idle_cycle();

    // randomized sequences
    for (int op = 0; op < 400; op++) begin
      int  nterms = $urandom_range(1, 3);
      int  mode   = $urandom_range(0, 2);
      bit  ub     = $urandom_range(0, 1);
      longint bias = longint'($signed($urandom));
      bit  sf     = $urandom_range(0, 1);
      bit  lm     = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) term(0, 0, rnd_prod(0), 0, 0, 0, 0);
      if ($urandom_range(0, 9) == 0) term(1, 0, rnd_prod(mode), ub, bias, 0, 0);
      for (int t = 0; t < nterms; t++) begin
        if (t > 0 && $urandom_range(0, 3) == 0) idle_cycle();
        term(t == 0, t == nterms - 1, rnd_prod(mode), ub, bias, sf, lm);
      end
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

    for (int w = 0; w < 10 && sb.size() != 0; w++) idle_cycle();
    idle_cycle();
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gte_mac_accum.md
Name: gte_mac_accum

Overview:
- Downstream neighbour of the GTE operand-select/multiply path.
- Consumes one signed 35-bit product per cycle and accumulates up to three terms, with an optional 32-bit translation/far-colour bias pre-shifted by 12, into a 44-bit MAC register.
- On the last term it applies the sf shift and produces the 32-bit MAC result, the 16-bit saturated IR result and the GTE-style overflow/saturation flags.
- Its outputs feed the MACn/IRn register write-back and the FLAG register logic.

Parameters:
- PROD_W, 35: signed product input width.
- ACC_W, 44: accumulator width; hardware overflow limit for the MAC1..3 flags.
- SHIFT, 12: right-shift amount applied when i_sf=1; also the left-shift applied to the bias.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: synchronous reset, active-high.
- i_valid, input, 1: product term present this cycle.
- i_first, input, 1: qualifies i_valid; this term starts a new accumulation.
- i_last, input, 1: qualifies i_valid; this term ends the accumulation.
- i_product, input, PROD_W: signed product from the multiply path.
- i_useBias, input, 1: sampled with the first term; adds the bias.
- i_bias, input, 32: signed TR/BK/FC component, sampled with the first term.
- i_sf, input, 1: sampled with the last term; 1 = arithmetic shift right by SHIFT.
- i_lm, input, 1: sampled with the last term; 1 = IR lower clamp 0, else -32768.
- o_valid, output, 1: one-cycle pulse; result outputs are valid.
- o_mac, output, 32: shifted accumulator, bits [31:0].
- o_ir, output, 16: saturated IR value.
- o_ovfPos, output, 1: sticky; accumulator exceeded +2^(ACC_W-1)-1 at any step.
- o_ovfNeg, output, 1: sticky; accumulator fell below -2^(ACC_W-1) at any step.
- o_irSat, output, 1: IR clamp occurred.
- o_busy, output, 1: accumulation in progress.

Behaviour:
- Reset: all outputs 0. State returns to IDLE. Accumulator and sticky flags cleared. Applies even mid-accumulation; a partial sum is discarded and no o_valid is produced.
- States: IDLE, ACCUM, DONE.
  - IDLE: waits for i_valid&i_first.
  - ACCUM: o_busy=1.
  - DONE: a single cycle with o_valid=1, then IDLE, or ACCUM if a new first term arrives in that same cycle.
- First term (i_valid&i_first):
  - acc = sext(i_product) + (i_useBias ? sext(i_bias)<<SHIFT : 0).
  - Flags are cleared, then updated by this add.
- Subsequent terms (i_valid, not first): acc = acc + sext(i_product).
- Overflow check: every add is computed at ACC_W+2 bits. If the result is above the signed ACC_W range, o_ovfPos is set (sticky). If below, o_ovfNeg is set (sticky). The stored acc is truncated (wrapped) to ACC_W bits; there is no clamping of acc.
- Last term:
  - The next cycle latches the outputs:
    - s = i_sf ? acc>>>SHIFT : acc.
    - o_mac = s[31:0].
    - o_ir = clamp(o_mac as signed 32, lo, 32767), where lo = i_lm ? 0 : -32768.
    - o_irSat = 1 if the clamp changed the value.
  - o_valid is high for exactly 1 cycle; latency is 1 cycle from the last term.
  - o_mac, o_ir and the flags hold until the next result or reset.
- i_first&i_last in the same cycle: single-term operation; bias and product are both applied.
- i_first while in ACCUM: restarts the accumulation; the old partial sum is dropped and no o_valid is produced for it.
- i_valid without i_first in IDLE: ignored; no state change.
- Cycles in ACCUM with i_valid=0: acc holds; there is no timeout.
- Term count is not limited in hardware; the sequencer guarantees at most 3 terms.
- Back-to-back operations are allowed: a first term may arrive in the DONE cycle.

Test Plan:
1. Basic accumulation: three terms of 409600 (4096*100), sf=1, lm=0, useBias=0 -> o_valid 1 cycle after last; o_mac=300, o_ir=300, all flags 0.
2. Bias and positive overflow: first term bias=0x7FFFFFFF, useBias=1, product=8192, last=1 -> o_ovfPos=1; o_mac equals the wrapped (negative) 44-bit value's bits[31:0] with sf=0; o_ovfNeg=0.
3. lm clamp: single term product=-20480, sf=1 -> lm=1 gives o_mac=-5, o_ir=0, o_irSat=1; lm=0 gives o_ir=-5, o_irSat=0.
4. Upper saturation: product=65536*4096, sf=1 -> o_mac=65536, o_ir=0x7FFF, o_irSat=1.
5. Restart and stray valid:
   - stray i_valid without first in IDLE -> no o_busy.
   - first(100), then first(7)+last with sf=0 -> o_mac=7 and only one o_valid pulse.
6. Reset mid-operation: i_rst asserted after the second term -> next cycle o_busy=0 and all outputs 0; a following three-term sequence yields the correct fresh result.
